axi4_lite_subordinate: RTL and testbench
========================================

// Module: axi4_lite_subordinate
//
// PURPOSE
//   Downstream counterpart of axi4_lite_manager: terminates one AXI4-Lite bus on the axi4_lite
//   interface (subordinate modport) and drives a simple single-access register port into one
//   peripheral (GPIO, UART, timer). Handles one transaction at a time.
//   Converts AW/W/B and AR/R handshakes into rd_en/wr_en requests closed by a peripheral ack.
//   Generates SLVERR on misaligned access or on peripheral timeout.
//
// PARAMETERS
//   WIDTH       32                   data width; strobe width is WIDTH/8
//   ADDR_WIDTH  32                   address width
//   TIMEOUT     DEFAULT_AXI_TIMEOUT  cycles to wait for ack before SLVERR (>=1)
//
// PORTS
//   clk           in   1             single clock, all logic on posedge
//   rst           in   1             synchronous, active-high reset
//   axi_s         if   -             axi4_lite.subordinate (AW, W, B, AR, R channels)
//   rd_en         out  1             read request, held until ack or timeout
//   wr_en         out  1             write request, held until ack or timeout
//   addr          out  ADDR_WIDTH    latched araddr/awaddr
//   wr_data       out  WIDTH         latched wdata
//   wr_strobe     out  WIDTH/8       latched wstrb
//   rd_data       in   WIDTH         peripheral read data, sampled on ack
//   ack           in   1             peripheral completes current request
//   access_fault  in   1             peripheral error, sampled with ack -> SLVERR
//
// BEHAVIOUR
//   Reset:
//     - all outputs 0: awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, rd_en,
//       wr_en, addr, wr_data, wr_strobe
//     - state IDLE; held AW/W flags cleared
//     - reset mid-transaction aborts it; no response issued
//   States: IDLE, RD_ACC, RD_RESP, WR_ACC, WR_RESP (axi_sub_state_t).
//   IDLE:
//     - arready=1
//     - awready=1 while no AW held; wready=1 while no W held
//     - AW and W accepted independently, in either order or the same cycle
//   Arbitration:
//     - AR handshake with AW+W not both held -> RD_ACC
//     - AW+W both held with no AR -> WR_ACC
//     - AR completing in the same cycle the write pair is complete -> round-robin: the
//       opposite direction to the last one served wins (write first after reset)
//     - the loser stays pending: AR held if arready was 1 at the handshake; AW/W stay held
//   RD_ACC:
//     - rd_en=1, addr=araddr
//     - ack -> RD_RESP, rdata=rd_data, rresp = access_fault ? SLVERR : OKAY
//     - ack in the first RD_ACC cycle is legal
//     - latency: AR handshake at edge N -> rd_en in cycle N+1 -> ack in N+1 -> rvalid at N+2
//   RD_RESP: rvalid=1 until rready; rvalid and rdata stable while waiting; -> IDLE.
//   WR_ACC: wr_en=1; ack -> WR_RESP, bresp = access_fault ? SLVERR : OKAY.
//   WR_RESP: bvalid=1 until bready; held AW/W flags cleared on the B handshake; -> IDLE.
//   Timeout:
//     - counter clears on entering *_ACC and counts each cycle without ack
//     - at TIMEOUT: drop rd_en/wr_en, go to *_RESP with SLVERR, rdata=0
//   Misalignment:
//     - addr[1:0]!=0 skips *_ACC (no rd_en/wr_en) and goes straight to *_RESP with SLVERR
//     - the write check applies regardless of wstrb
//   ack outside *_ACC is ignored.
//   rd_en and wr_en are never both 1.
//
// STRUCTURE
//   - saratoga package: typedef enum axi_sub_state_t; DEFAULT_AXI_TIMEOUT (existing);
//     AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10 if not already exported
//   - one sub-module: axi4_lite_sub_timeout (load/count/expire counter, $clog2(TIMEOUT+1) bits)
//   - everything else is flat
//
// TESTING
//   1. AR 0x0000_0010, ack 2 cycles later, rd_data 0xDEAD_BEEF -> rvalid, rdata=0xDEADBEEF,
//      rresp=OKAY; rd_en high exactly 2 cycles.
//   2. W 0xA5A5_A5A5 strb 4'b0011 one cycle before AW 0x20, immediate ack -> wr_en 1 cycle,
//      wr_data/wr_strobe match, bresp=OKAY; hold bready low 3 cycles -> bvalid stable.
//   3. AR 0x0000_0006 -> rresp=SLVERR, rd_en never asserted; AW 0x0000_0003 -> bresp=SLVERR,
//      wr_en never asserted.
//   4. AR with ack held low -> rd_en drops after TIMEOUT cycles, rresp=SLVERR, rdata=0.
//   5. AR and completed AW+W in the same cycle after reset -> write served first, then read;
//      repeat -> read first.
//   6. rst asserted during RD_ACC -> next cycle all outputs 0; after release, a fresh read
//      completes normally; ack with access_fault=1 -> SLVERR.

Source files
------------

// File: rtl/saratoga_pkg.sv
// Shared AXI4-Lite subordinate types, response codes and the default ack timeout.
package saratoga_pkg;

  localparam int DEFAULT_AXI_TIMEOUT = 16;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    RD_RESP,
    WR_ACC,
    WR_RESP
  } axi_sub_state_t;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/axi4_lite.sv
// AXI4-Lite bundle: AW, W, B, AR and R channels with manager and subordinate views.
interface axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport manager (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport subordinate (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_sub_timeout.sv
// Ack watchdog: cleared by load, advanced by count, expired after TIMEOUT counted cycles.
// Expiry is combinational from the count; the count saturates once expired.
module axi4_lite_sub_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // The first access cycle sees cnt_q == 0, so expiry lands on the TIMEOUT-th cycle.
  assign expired = (cnt_q >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (count && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/axi4_lite_subordinate.sv
// AXI4-Lite to single-access register port bridge, one transaction in flight.
// AR handshake to rd_en in one cycle, response one cycle after ack; channel readies drop while busy.
module axi4_lite_subordinate
  import saratoga_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_AXI_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4_lite.subordinate         axi_s,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH/8-1:0]    wr_strobe,
  input  logic [WIDTH-1:0]      rd_data,
  input  logic                  ack,
  input  logic                  access_fault
);

  axi_sub_state_t state_q, state_d;

  logic                  live_q;
  logic                  ar_held_q, aw_held_q, w_held_q;
  logic                  rr_wr_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q, aw_addr_q, addr_q;
  logic [WIDTH-1:0]      wdata_q, rdata_q;
  logic [WIDTH/8-1:0]    wstrb_q;
  logic [1:0]            rresp_q, bresp_q;

  logic                  in_idle, ar_hs, aw_hs, w_hs, b_hs;
  logic                  rd_pend, wr_pend, pick_rd, pick_wr;
  logic                  in_acc, acc_done, expired;
  logic [ADDR_WIDTH-1:0] cur_araddr, cur_awaddr;

  // live_q keeps every ready low for the first cycle out of reset.
  assign in_idle = live_q && (state_q == IDLE);

  assign axi_s.arready = in_idle && !ar_held_q;
  assign axi_s.awready = in_idle && !aw_held_q;
  assign axi_s.wready  = in_idle && !w_held_q;
  assign axi_s.rvalid  = (state_q == RD_RESP);
  assign axi_s.bvalid  = (state_q == WR_RESP);
  assign axi_s.rdata   = rdata_q;
  assign axi_s.rresp   = rresp_q;
  assign axi_s.bresp   = bresp_q;

  assign rd_en     = (state_q == RD_ACC);
  assign wr_en     = (state_q == WR_ACC);
  assign addr      = addr_q;
  assign wr_data   = wdata_q;
  assign wr_strobe = wstrb_q;

  assign ar_hs = axi_s.arvalid && axi_s.arready;
  assign aw_hs = axi_s.awvalid && axi_s.awready;
  assign w_hs  = axi_s.wvalid && axi_s.wready;
  assign b_hs  = (state_q == WR_RESP) && axi_s.bready;

  assign rd_pend    = ar_held_q || ar_hs;
  assign wr_pend    = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign cur_araddr = ar_hs ? axi_s.araddr : ar_addr_q;
  assign cur_awaddr = aw_hs ? axi_s.awaddr : aw_addr_q;

  assign in_acc   = (state_q == RD_ACC) || (state_q == WR_ACC);
  assign acc_done = ack || expired;

  axi4_lite_sub_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (pick_rd || pick_wr),
    .count   (in_acc && !ack),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    pick_rd = 1'b0;
    pick_wr = 1'b0;
    case (state_q)
      IDLE: begin
        // Only a genuine collision consults and flips the round-robin pointer.
        if (rd_pend && wr_pend) begin
          pick_wr = rr_wr_q;
          pick_rd = !rr_wr_q;
        end else begin
          pick_rd = rd_pend;
          pick_wr = wr_pend;
        end
        if (pick_rd) begin
          state_d = addr_misaligned(cur_araddr[1:0]) ? RD_RESP : RD_ACC;
        end else if (pick_wr) begin
          state_d = addr_misaligned(cur_awaddr[1:0]) ? WR_RESP : WR_ACC;
        end
      end
      RD_ACC:  if (acc_done) state_d = RD_RESP;
      RD_RESP: if (axi_s.rready) state_d = IDLE;
      WR_ACC:  if (acc_done) state_d = WR_RESP;
      WR_RESP: if (axi_s.bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      ar_held_q <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      rr_wr_q   <= 1'b1;
      ar_addr_q <= '0;
      aw_addr_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;

      if (ar_hs) ar_addr_q <= axi_s.araddr;
      if (aw_hs) aw_addr_q <= axi_s.awaddr;
      if (w_hs) begin
        wdata_q <= axi_s.wdata;
        wstrb_q <= axi_s.wstrb;
      end

      if (pick_rd)    ar_held_q <= 1'b0;
      else if (ar_hs) ar_held_q <= 1'b1;
      if (b_hs)       aw_held_q <= 1'b0;
      else if (aw_hs) aw_held_q <= 1'b1;
      if (b_hs)       w_held_q  <= 1'b0;
      else if (w_hs)  w_held_q  <= 1'b1;

      if (pick_rd && pick_wr == 1'b0 && rd_pend && wr_pend) rr_wr_q <= 1'b1;
      if (pick_wr && rd_pend && wr_pend)                    rr_wr_q <= 1'b0;

      if (pick_rd) begin
        addr_q <= cur_araddr;
        if (addr_misaligned(cur_araddr[1:0])) begin
          rdata_q <= '0;
          rresp_q <= AXI_RESP_SLVERR;
        end
      end
      if (pick_wr) begin
        addr_q <= cur_awaddr;
        if (addr_misaligned(cur_awaddr[1:0])) bresp_q <= AXI_RESP_SLVERR;
      end

      // A late ack in the expiry cycle still wins over the timeout.
      if (state_q == RD_ACC && acc_done) begin
        rdata_q <= ack ? rd_data : '0;
        rresp_q <= (ack && !access_fault) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
      if (state_q == WR_ACC && acc_done) begin
        bresp_q <= (ack && !access_fault) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_subordinate.sv
// Directed bench for axi4_lite_subordinate with a peripheral model and scoreboarded R/B/access monitors.
module tb_axi4_lite_subordinate;

  localparam int TMO = 6;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [7:0]  len;
  } acc_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en, wr_en;
  logic [31:0] addr, wr_data;
  logic [3:0]  wr_strobe;
  logic [31:0] rd_data = '0;
  logic        ack = 1'b0;
  logic        access_fault = 1'b0;

  int   vectors = 0;
  int   miscompares = 0;
  int   ack_delay = 1;
  bit   abort = 1'b0;

  acc_t    exp_acc[$];
  r_t      exp_r[$];
  logic [1:0] exp_b[$];

  axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_subordinate #(
    .WIDTH      (32),
    .ADDR_WIDTH (32),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .axi_s        (axi),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .addr         (addr),
    .wr_data      (wr_data),
    .wr_strobe    (wr_strobe),
    .rd_data      (rd_data),
    .ack          (ack),
    .access_fault (access_fault)
  );

  always #5 clk = ~clk;

  wire [110:0] all_outs = {axi.arready, axi.awready, axi.wready, axi.bvalid, axi.rvalid,
                           axi.bresp, axi.rresp, axi.rdata, rd_en, wr_en, addr, wr_data, wr_strobe};

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic void push_acc(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input logic [7:0] len);
    acc_t e;
    e.wr = wr; e.addr = a; e.wdata = d; e.strb = s; e.len = len;
    exp_acc.push_back(e);
  endfunction

  function automatic void push_r(input logic [31:0] d, input logic [1:0] resp);
    r_t e;
    e.data = d; e.resp = resp;
    exp_r.push_back(e);
  endfunction

  // Peripheral model: acks after ack_delay enable cycles (0 = never) and checks each access.
  initial begin : periph
    int   cyc;
    acc_t cap;
    acc_t e;
    cyc = 0;
    cap = '0;
    forever begin
      @(negedge clk); #1;
      if ((rd_en || wr_en) && !abort) begin
        if (cyc == 0) begin
          cap.wr = wr_en; cap.addr = addr; cap.wdata = wr_data; cap.strb = wr_strobe;
          chk("en_exclusive", {rd_en, wr_en} == 2'b11, 1'b0);
        end
        cyc++;
        ack = (cyc == ack_delay);
      end else begin
        ack = 1'b0;
        if (cyc != 0 && !abort) begin
          if (exp_acc.size() == 0) begin
            chk("acc_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_acc.pop_front();
            chk("acc_dir", cap.wr, e.wr);
            chk("acc_addr", cap.addr, e.addr);
            chk("acc_len", cyc, e.len);
            if (e.wr) begin
              chk("acc_wdata", cap.wdata, e.wdata);
              chk("acc_wstrb", cap.strb, e.strb);
            end
          end
        end
        cyc = 0;
      end
    end
  end

  // Response monitor: pops on each R/B handshake and checks stability while stalled.
  initial begin : resp_mon
    bit         r_wait, b_wait;
    r_t         r_sav, r_e;
    logic [1:0] b_sav;
    r_wait = 0; b_wait = 0; r_sav = '0; b_sav = '0;
    forever begin
      @(negedge clk); #2;
      if (r_wait) chk("r_stable", {axi.rvalid, axi.rdata, axi.rresp}, {1'b1, r_sav});
      if (b_wait) chk("b_stable", {axi.bvalid, axi.bresp}, {1'b1, b_sav});
      r_wait = axi.rvalid && !axi.rready;
      b_wait = axi.bvalid && !axi.bready;
      r_sav  = {axi.rdata, axi.rresp};
      b_sav  = axi.bresp;
      if (axi.rvalid && axi.rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1'b1, 1'b0);
        else begin
          r_e = exp_r.pop_front();
          chk("rdata", axi.rdata, r_e.data);
          chk("rresp", axi.rresp, r_e.resp);
        end
      end
      if (axi.bvalid && axi.bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1'b1, 1'b0);
        else chk("bresp", axi.bresp, exp_b.pop_front());
      end
    end
  end

  // Called at a negedge; drives the requested channels until each has handshaken.
  task automatic xfer(input bit do_ar, input bit do_aw, input bit do_w,
                      input logic [31:0] ara, input logic [31:0] awa,
                      input logic [31:0] wd, input logic [3:0] st);
    bit pa, pw, pd, ha, hw, hd;
    pa = do_ar; pw = do_aw; pd = do_w;
    axi.araddr = ara; axi.awaddr = awa; axi.wdata = wd; axi.wstrb = st;
    axi.arvalid = pa; axi.awvalid = pw; axi.wvalid = pd;
    for (int i = 0; i < 64 && (pa || pw || pd); i++) begin
      ha = pa && axi.arready;
      hw = pw && axi.awready;
      hd = pd && axi.wready;
      @(negedge clk);
      if (ha) begin pa = 0; axi.arvalid = 1'b0; end
      if (hw) begin pw = 0; axi.awvalid = 1'b0; end
      if (hd) begin pd = 0; axi.wvalid = 1'b0; end
    end
    chk("handshake_done", {pa, pw, pd}, 3'b000);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_acc.size() + exp_r.size() + exp_b.size()) != 0; i++)
      @(negedge clk);
    chk("scoreboard_empty", exp_acc.size() + exp_r.size() + exp_b.size(), 0);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk); #2;
    chk("reset_outputs", all_outs, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.araddr = '0; axi.arvalid = 1'b0; axi.bready = 1'b1; axi.rready = 1'b1;
    apply_reset();

    // 1: plain read, ack on the second enable cycle.
    ack_delay = 2; rd_data = 32'hDEAD_BEEF;
    push_acc(1'b0, 32'h10, '0, '0, 8'd2);
    push_r(32'hDEAD_BEEF, OKAY);
    xfer(1, 0, 0, 32'h10, '0, '0, '0);
    drain();

    // 2: W ahead of AW, immediate ack, B stalled for 3 cycles.
    ack_delay = 1;
    axi.bready = 1'b0;
    push_acc(1'b1, 32'h20, 32'hA5A5_A5A5, 4'b0011, 8'd1);
    exp_b.push_back(OKAY);
    xfer(0, 0, 1, '0, '0, 32'hA5A5_A5A5, 4'b0011);
    xfer(0, 1, 0, '0, 32'h20, '0, '0);
    for (int i = 0; i < 50 && !axi.bvalid; i++) @(negedge clk);
    chk("bvalid_seen", axi.bvalid, 1'b1);
    repeat (3) @(negedge clk);
    axi.bready = 1'b1;
    drain();

    // 3: misaligned read and write never reach the peripheral.
    push_r(32'h0, SLVERR);
    xfer(1, 0, 0, 32'h6, '0, '0, '0);
    drain();
    exp_b.push_back(SLVERR);
    xfer(0, 1, 1, '0, 32'h3, 32'h1234_5678, 4'b0000);
    drain();

    // 4: read timeout.
    ack_delay = 0; rd_data = 32'h1357_9BDF;
    push_acc(1'b0, 32'h40, '0, '0, 8'(TMO));
    push_r(32'h0, SLVERR);
    xfer(1, 0, 0, 32'h40, '0, '0, '0);
    drain();

    // 5: AR and AW+W colliding: write first after reset, read first on the repeat.
    apply_reset();
    ack_delay = 1; rd_data = 32'h1111_2222;
    push_acc(1'b1, 32'h80, 32'hCAFE_0001, 4'hF, 8'd1);
    push_acc(1'b0, 32'h84, '0, '0, 8'd1);
    exp_b.push_back(OKAY);
    push_r(32'h1111_2222, OKAY);
    xfer(1, 1, 1, 32'h84, 32'h80, 32'hCAFE_0001, 4'hF);
    drain();
    push_acc(1'b0, 32'h88, '0, '0, 8'd1);
    push_acc(1'b1, 32'h8C, 32'hCAFE_0002, 4'hF, 8'd1);
    exp_b.push_back(OKAY);
    push_r(32'h1111_2222, OKAY);
    xfer(1, 1, 1, 32'h88, 32'h8C, 32'hCAFE_0002, 4'hF);
    drain();

    // 6: reset in RD_ACC aborts silently; then normal read and faulted accesses.
    ack_delay = 0;
    xfer(1, 0, 0, 32'h30, '0, '0, '0);
    chk("rd_en_before_abort", rd_en, 1'b1);
    abort = 1'b1;
    rst = 1'b1;
    @(negedge clk); #2;
    chk("abort_outputs", all_outs, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    ack_delay = 2; rd_data = 32'h5555_AAAA;
    push_acc(1'b0, 32'h30, '0, '0, 8'd2);
    push_r(32'h5555_AAAA, OKAY);
    xfer(1, 0, 0, 32'h30, '0, '0, '0);
    drain();
    ack_delay = 1; access_fault = 1'b1; rd_data = 32'h0000_0077;
    push_acc(1'b0, 32'h38, '0, '0, 8'd1);
    push_r(32'h0000_0077, SLVERR);
    xfer(1, 0, 0, 32'h38, '0, '0, '0);
    drain();
    push_acc(1'b1, 32'h34, 32'hBEEF_0000, 4'b1100, 8'd1);
    exp_b.push_back(SLVERR);
    xfer(0, 1, 1, '0, 32'h34, 32'hBEEF_0000, 4'b1100);
    drain();
    access_fault = 1'b0;

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
